snake_body_controller: RTL and testbench
========================================

// Module: snake_body_controller
// PURPOSE
//  Grid-based snake engine; parametrised successor to the single-block mover.
//  Holds up to MAX_LEN segment coordinates in a shift array. Advances one grid cell per Tick strobe.
//  Handles growth, wrap-around and self-collision.
//  Renders head/body/background per VGA pixel from hCount/vCount for the display controller.
// PARAMETERS
//  MAX_LEN    16        maximum segments (>= INIT_LEN, <= 64)
//  INIT_LEN   3         length after reset / restart (>= 2)
//  GRID_W     40        grid columns (<= 64)
//  GRID_H     30        grid rows (<= 64)
//  CELL_SHIFT 4         cell edge = 2**CELL_SHIFT pixels
//  H_ORIGIN   144       hCount of first visible column
//  V_ORIGIN   35        vCount of first visible row
//  HEAD_RGB   12'hF00   head colour
//  BODY_RGB   12'h0F0   body colour while alive
//  DEAD_RGB   12'h888   head+body colour after death
//  BG_RGB     12'hFFF   in-grid background colour
// PORTS
//  Clk        in   1    system clock
//  Reset      in   1    asynchronous, active-high reset
//  Start      in   1    one-cycle pulse: IDLE->RUN, or DEAD->reinit->RUN
//  Tick       in   1    one-cycle move strobe (sets game speed)
//  Up/Down/Left/Right in 1 each  direction requests, level
//  Grow       in   1    one-cycle pulse: add one segment on the next move
//  Bright     in   1    display-area enable
//  hCount     in   10   pixel column counter
//  vCount     in   10   pixel row counter
//  rgb        out  12   registered pixel colour
//  head_x     out  6    head column
//  head_y     out  6    head row
//  length     out  7    current segment count
//  running    out  1    1 in RUN
//  dead       out  1    1 in DEAD
// BEHAVIOUR
//  Reset values: state IDLE; seg[0]=(GRID_W/2,GRID_H/2); seg[i]=(GRID_W/2-i,GRID_H/2).
//   length=INIT_LEN, dir=next_dir=RIGHT, grow_pend=0, running=0, dead=0, rgb=0.
//  FSM IDLE --Start--> RUN --collision--> DEAD --Start--> RUN.
//   DEAD->RUN reloads all reset values except state in the same edge.
//  Direction: in RUN, each cycle with a request latches next_dir; priority Up>Down>Left>Right.
//   A request opposite to current dir is dropped. dir<=next_dir on each accepted Tick.
//  Tick in RUN, one cycle:
//   new head = seg[0]+dir; wrap GRID_W-1->0, 0->GRID_W-1, same for rows.
//   grows = grow_pend | Grow.
//   collision if new head == seg[i] for 1<=i<length-1; when grows, i<length also counts.
//   No collision: seg[0]<=new head; seg[i]<=seg[i-1] for all i; if grows & length<MAX_LEN, length+1.
//   grow_pend<=0 whenever grows, incl. at MAX_LEN, where the grow is discarded.
//   Collision: segments/length frozen; state DEAD; dead=1, running=0 from next cycle.
//  Grow without Tick sets sticky grow_pend; multiple Grows before a Tick count once.
//  Tick/Grow/direction ignored in IDLE and DEAD. Start ignored in RUN.
//  Render, 1-cycle latency: col=(hCount-H_ORIGIN)>>CELL_SHIFT; row likewise from vCount/V_ORIGIN.
//   ~Bright, or hCount/vCount below origin, or col>=GRID_W, or row>=GRID_H -> rgb=0.
//   Else cell==seg[0] -> HEAD_RGB; cell==seg[i], 1<=i<length -> BODY_RGB; else BG_RGB.
//   HEAD_RGB/BODY_RGB replaced by DEAD_RGB in DEAD.
//   Entries i>=length are never drawn or collision-checked.
//  Reset asserted mid-move or mid-frame: all state returns to reset values immediately.
// CONFIGURATION
//  SNAKE_WALL_KILL_EN defined: a move leaving the grid is a collision (-> DEAD, head not updated).
//  Undefined: edges wrap as above.
// TESTING
//  Reset, Start, 3 Ticks -> head (23,15), length 3, running=1, dead=0.
//  dir RIGHT, Left held, Tick -> head x+1, dir stays RIGHT; Up then Tick -> head y-1.
//  Head (39,15) dir RIGHT, Tick -> head (0,15); with SNAKE_WALL_KILL_EN -> dead=1, head (39,15).
//  Grow pulse then Tick -> length 4; Grow at length 16 + Tick -> length 16, grow_pend=0.
//  INIT_LEN=5, Start, Up/Tick, Left/Tick, Down/Tick -> 3rd move hits (19,15) -> dead=1, length 5.
//  Bright=1, hCount=467, vCount=278 (cell 20,15) -> rgb=12'hF00 next cycle; Bright=0 -> rgb=0.

Source files
------------

// File: rtl/snake_body_controller.sv
// Grid snake engine: segment shift array, direction/grow handling, self-collision and pixel render.
// Define SNAKE_WALL_KILL_EN to make leaving the grid fatal instead of wrapping.
module snake_body_controller #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned INIT_LEN   = 3,
  parameter int unsigned GRID_W     = 40,
  parameter int unsigned GRID_H     = 30,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned H_ORIGIN   = 144,
  parameter int unsigned V_ORIGIN   = 35,
  parameter logic [11:0] HEAD_RGB   = 12'hF00,
  parameter logic [11:0] BODY_RGB   = 12'h0F0,
  parameter logic [11:0] DEAD_RGB   = 12'h888,
  parameter logic [11:0] BG_RGB     = 12'hFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Tick,
  input  logic        Up,
  input  logic        Down,
  input  logic        Left,
  input  logic        Right,
  input  logic        Grow,
  input  logic        Bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [5:0]  head_x,
  output logic [5:0]  head_y,
  output logic [6:0]  length,
  output logic        running,
  output logic        dead
);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;
  typedef enum logic [1:0] {DirRight, DirLeft, DirUp, DirDown} dir_e;

  localparam logic [5:0] XMax = 6'(GRID_W - 1);
  localparam logic [5:0] YMax = 6'(GRID_H - 1);

  function automatic logic [5:0] init_x(int i);
    return 6'(int'(GRID_W / 2) - i);
  endfunction

  function automatic dir_e opposite(dir_e d);
    unique case (d)
      DirRight: return DirLeft;
      DirLeft:  return DirRight;
      DirUp:    return DirDown;
      DirDown:  return DirUp;
    endcase
  endfunction

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d, nd_q, nd_d, req;
  logic        grow_q, grow_d;
  logic [6:0]  len_q, len_d;
  logic [5:0]  seg_x_q [MAX_LEN];
  logic [5:0]  seg_y_q [MAX_LEN];
  logic [5:0]  seg_x_d [MAX_LEN];
  logic [5:0]  seg_y_d [MAX_LEN];
  logic [5:0]  nx, ny;
  logic        grows, hit;
  logic [11:0] rgb_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    nd_d    = nd_q;
    grow_d  = grow_q;
    len_d   = len_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    req     = DirRight;
    nx      = seg_x_q[0];
    ny      = seg_y_q[0];
    grows   = grow_q | Grow;

    // The move uses the latched request so a turn takes effect on the very next Tick.
    unique case (nd_q)
      DirRight: nx = (seg_x_q[0] == XMax) ? 6'd0 : seg_x_q[0] + 6'd1;
      DirLeft:  nx = (seg_x_q[0] == 6'd0) ? XMax : seg_x_q[0] - 6'd1;
      DirUp:    ny = (seg_y_q[0] == 6'd0) ? YMax : seg_y_q[0] - 6'd1;
      DirDown:  ny = (seg_y_q[0] == YMax) ? 6'd0 : seg_y_q[0] + 6'd1;
    endcase

`ifdef SNAKE_WALL_KILL_EN
    hit = (nd_q == DirRight && seg_x_q[0] == XMax) || (nd_q == DirLeft && seg_x_q[0] == 6'd0) ||
          (nd_q == DirUp && seg_y_q[0] == 6'd0)    || (nd_q == DirDown && seg_y_q[0] == YMax);
`else
    hit = 1'b0;
`endif
    // The tail cell vacates on a plain move, so it only counts when growing.
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if (((7'(i) < len_q - 7'd1) || (grows && 7'(i) < len_q)) &&
          nx == seg_x_q[i] && ny == seg_y_q[i]) begin
        hit = 1'b1;
      end
    end

    case (state_q)
      StRun: begin
        if (Up || Down || Left || Right) begin
          req = Up ? DirUp : Down ? DirDown : Left ? DirLeft : DirRight;
          if (req != opposite(dir_q)) nd_d = req;
        end
        if (Tick) begin
          grow_d = 1'b0;
          if (hit) begin
            state_d = StDead;
          end else begin
            dir_d = nd_q;
            for (int i = 1; i < int'(MAX_LEN); i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            if (grows && len_q < 7'(MAX_LEN)) len_d = len_q + 7'd1;
          end
        end else if (Grow) begin
          grow_d = 1'b1;
        end
      end
      default: begin
        if (Start) begin
          state_d = StRun;
          dir_d   = DirRight;
          nd_d    = DirRight;
          grow_d  = 1'b0;
          len_d   = 7'(INIT_LEN);
          for (int i = 0; i < int'(MAX_LEN); i++) begin
            seg_x_d[i] = init_x(i);
            seg_y_d[i] = 6'(GRID_H / 2);
          end
        end
      end
    endcase
  end

  logic [9:0] h_off, v_off, col, row;
  logic       in_grid, is_head, is_body;

  always_comb begin
    h_off   = hCount - 10'(H_ORIGIN);
    v_off   = vCount - 10'(V_ORIGIN);
    col     = h_off >> CELL_SHIFT;
    row     = v_off >> CELL_SHIFT;
    in_grid = Bright && (hCount >= 10'(H_ORIGIN)) && (vCount >= 10'(V_ORIGIN)) &&
              (col < 10'(GRID_W)) && (row < 10'(GRID_H));
    is_head = (col[5:0] == seg_x_q[0]) && (row[5:0] == seg_y_q[0]);
    is_body = 1'b0;
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if (7'(i) < len_q && col[5:0] == seg_x_q[i] && row[5:0] == seg_y_q[i]) is_body = 1'b1;
    end
    rgb_d = 12'h000;
    if (in_grid) begin
      if (is_head)      rgb_d = (state_q == StDead) ? DEAD_RGB : HEAD_RGB;
      else if (is_body) rgb_d = (state_q == StDead) ? DEAD_RGB : BODY_RGB;
      else              rgb_d = BG_RGB;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      dir_q   <= DirRight;
      nd_q    <= DirRight;
      grow_q  <= 1'b0;
      len_q   <= 7'(INIT_LEN);
      rgb     <= 12'h000;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= 6'(GRID_H / 2);
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      nd_q    <= nd_d;
      grow_q  <= grow_d;
      len_q   <= len_d;
      rgb     <= rgb_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
    end
  end

  assign head_x  = seg_x_q[0];
  assign head_y  = seg_y_q[0];
  assign length  = len_q;
  assign running = (state_q == StRun);
  assign dead    = (state_q == StDead);

endmodule

// File: tb/tb_snake_body_controller.sv
// Bench for snake_body_controller: directed scenarios plus random play against a queue-based model.
module tb_snake_body_controller;

  localparam int MaxLen = 16;
  localparam int InitLen = 3;
  localparam int GridW = 40;
  localparam int GridH = 30;

  logic        Clk = 1'b0;
  logic        Reset, Start, Tick, Up, Down, Left, Right, Grow, Bright;
  logic [9:0]  hCount, vCount;
  logic [11:0] rgb, rgb5;
  logic [5:0]  head_x, head_y, head_x5, head_y5;
  logic [6:0]  length, length5;
  logic        running, dead, running5, dead5;

  int n_pass = 0;
  int n_total = 0;

  // Model: snake as coordinate queues, head at index 0; dirs 0=R 1=L 2=U 3=D.
  int m_state, m_dir, m_nd, m_grow;
  int m_x[$];
  int m_y[$];

  snake_body_controller u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Tick(Tick), .Up(Up), .Down(Down), .Left(Left),
    .Right(Right), .Grow(Grow), .Bright(Bright), .hCount(hCount), .vCount(vCount), .rgb(rgb),
    .head_x(head_x), .head_y(head_y), .length(length), .running(running), .dead(dead)
  );

  snake_body_controller #(.INIT_LEN(5)) u_dut5 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Tick(Tick), .Up(Up), .Down(Down), .Left(Left),
    .Right(Right), .Grow(Grow), .Bright(Bright), .hCount(hCount), .vCount(vCount), .rgb(rgb5),
    .head_x(head_x5), .head_y(head_y5), .length(length5), .running(running5), .dead(dead5)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_init();
    m_x.delete();
    m_y.delete();
    for (int i = 0; i < InitLen; i++) begin
      m_x.push_back(GridW / 2 - i);
      m_y.push_back(GridH / 2);
    end
    m_dir = 0;
    m_nd = 0;
    m_grow = 0;
  endfunction

  function automatic int model_rgb();
    int col, row;
    if (!Bright || hCount < 144 || vCount < 35) return 0;
    col = (int'(hCount) - 144) / 16;
    row = (int'(vCount) - 35) / 16;
    if (col >= GridW || row >= GridH) return 0;
    if (col == m_x[0] && row == m_y[0]) return (m_state == 2) ? 'h888 : 'hF00;
    for (int i = 1; i < m_x.size(); i++)
      if (col == m_x[i] && row == m_y[i]) return (m_state == 2) ? 'h888 : 'h0F0;
    return 'hFFF;
  endfunction

  function automatic void model_step();
    int new_nd, req, dx, dy, rx, ry, nx, ny, sz, hit;
    bit grows;
    if (m_state != 1) begin
      if (Start) begin
        model_init();
        m_state = 1;
      end
      return;
    end
    new_nd = m_nd;
    req = Up ? 2 : Down ? 3 : Left ? 1 : Right ? 0 : -1;
    if (req >= 0 && req != (m_dir ^ 1)) new_nd = req;
    if (Tick) begin
      grows = (m_grow != 0) || Grow;
      m_grow = 0;
      dx = (m_nd == 0) ? 1 : (m_nd == 1) ? -1 : 0;
      dy = (m_nd == 3) ? 1 : (m_nd == 2) ? -1 : 0;
      rx = m_x[0] + dx;
      ry = m_y[0] + dy;
      hit = 0;
`ifdef SNAKE_WALL_KILL_EN
      if (rx < 0 || rx >= GridW || ry < 0 || ry >= GridH) hit = 1;
`endif
      nx = (rx + GridW) % GridW;
      ny = (ry + GridH) % GridH;
      sz = m_x.size();
      for (int i = 1; i < (grows ? sz : sz - 1); i++)
        if (nx == m_x[i] && ny == m_y[i]) hit = 1;
      if (hit != 0) begin
        m_state = 2;
      end else begin
        m_dir = m_nd;
        m_x.push_front(nx);
        m_y.push_front(ny);
        if (!(grows && sz < MaxLen)) begin
          void'(m_x.pop_back());
          void'(m_y.pop_back());
        end
      end
    end else if (Grow) begin
      m_grow = 1;
    end
    m_nd = new_nd;
  endfunction

  task automatic check_model(input logic [31:0] exp_rgb);
    check("rgb", rgb, exp_rgb);
    check("head_x", head_x, m_x[0]);
    check("head_y", head_y, m_y[0]);
    check("length", length, m_x.size());
    check("running", running, m_state == 1);
    check("dead", dead, m_state == 2);
  endtask

  task automatic cycle();
    int exp_rgb;
    exp_rgb = model_rgb();
    @(posedge Clk);
    model_step();
    #1;
    check_model(exp_rgb);
  endtask

  task automatic cyc(input logic st, input logic tk, input logic gr, input logic [3:0] udlr);
    Start = st;
    Tick = tk;
    Grow = gr;
    {Up, Down, Left, Right} = udlr;
    cycle();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    {Start, Tick, Grow, Up, Down, Left, Right} = '0;
    #2;
    m_state = 0;
    model_init();
    check_model(0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    int r, idx;
    Reset = 1'b0;
    {Start, Tick, Grow, Up, Down, Left, Right, Bright} = '0;
    hCount = '0;
    vCount = '0;
    m_state = 0;
    model_init();
    @(posedge Clk);
    #1;
    do_reset();

    // Rendering of the idle snake
    Bright = 1'b1; hCount = 10'd467; vCount = 10'd278;
    cyc(0, 0, 0, 4'b0000);
    check("rgb_head_cell", rgb, 12'hF00);
    hCount = 10'd448;
    cyc(0, 0, 0, 4'b0000);
    check("rgb_body_cell", rgb, 12'h0F0);
    hCount = 10'd144; vCount = 10'd35;
    cyc(0, 0, 0, 4'b0000);
    check("rgb_bg_corner", rgb, 12'hFFF);
    hCount = 10'd784;
    cyc(0, 0, 0, 4'b0000);
    check("rgb_right_of_grid", rgb, 12'h000);
    Bright = 1'b0; hCount = 10'd467; vCount = 10'd278;
    cyc(0, 0, 0, 4'b0000);
    check("rgb_blank", rgb, 12'h000);

    // Start and three moves
    cyc(1, 0, 0, 4'b0000);
    repeat (3) cyc(0, 1, 0, 4'b0000);
    check("run3_x", head_x, 6'd23);
    check("run3_y", head_y, 6'd15);
    check("run3_len", length, 7'd3);
    check("run3_running", running, 1'b1);
    check("run3_dead", dead, 1'b0);

    // Reverse request dropped, turn accepted
    cyc(0, 1, 0, 4'b0010);
    check("rev_tick_x", head_x, 6'd24);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 1, 0, 4'b0000);
    check("rev_held_x", head_x, 6'd25);
    cyc(0, 0, 0, 4'b1000);
    cyc(0, 1, 0, 4'b0000);
    check("turn_up_y", head_y, 6'd14);
    check("turn_up_x", head_x, 6'd25);

    // Right-edge behaviour
    do_reset();
    cyc(1, 0, 0, 4'b0000);
    repeat (19) cyc(0, 1, 0, 4'b0000);
    check("edge_x", head_x, 6'd39);
    cyc(0, 1, 0, 4'b0000);
`ifdef SNAKE_WALL_KILL_EN
    check("wall_dead", dead, 1'b1);
    check("wall_x", head_x, 6'd39);
`else
    check("wrap_x", head_x, 6'd0);
    check("wrap_y", head_y, 6'd15);
    check("wrap_running", running, 1'b1);
`endif

    // Growth, repeated pulses, saturation
    do_reset();
    cyc(1, 0, 0, 4'b0000);
    cyc(0, 0, 1, 4'b0000);
    cyc(0, 1, 0, 4'b0000);
    check("grow_len4", length, 7'd4);
    cyc(0, 0, 1, 4'b0000);
    cyc(0, 0, 1, 4'b0000);
    cyc(0, 1, 0, 4'b0000);
    check("grow_once_len5", length, 7'd5);
    repeat (11) cyc(0, 1, 1, 4'b0000);
    check("grow_len16", length, 7'd16);
    cyc(0, 1, 1, 4'b0000);
    check("grow_sat_len", length, 7'd16);
    cyc(0, 1, 0, 4'b0000);
    check("grow_sat_after", length, 7'd16);

    // U-turn into own body on the five-segment instance
    do_reset();
    cyc(1, 0, 0, 4'b0000);
    cyc(0, 0, 0, 4'b1000);
    cyc(0, 1, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0010);
    cyc(0, 1, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0100);
    cyc(0, 1, 0, 4'b0000);
    check("len5_dead", dead5, 1'b1);
    check("len5_running", running5, 1'b0);
    check("len5_length", length5, 7'd5);
    check("len5_head_x", head_x5, 6'd19);
    check("len5_head_y", head_y5, 6'd14);

    // Random play
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      Bright = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      if (r == 0) begin
        hCount = 10'(144 + m_x[0] * 16 + $urandom_range(0, 15));
        vCount = 10'(35 + m_y[0] * 16 + $urandom_range(0, 15));
      end else if (r == 1) begin
        idx = $urandom_range(1, m_x.size() - 1);
        hCount = 10'(144 + m_x[idx] * 16 + $urandom_range(0, 15));
        vCount = 10'(35 + m_y[idx] * 16 + $urandom_range(0, 15));
      end else begin
        hCount = 10'($urandom_range(100, 820));
        vCount = 10'($urandom_range(0, 540));
      end
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0),
          {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
